// File: rtl/vga_out_pkg.sv
// Shared types and helpers for the VGA output quantiser: mode encoding,
// recursive Bayer matrix entry, and offset scaling for round/dither modes.
// Purely combinational helpers; no latency, no backpressure.
package vga_out_pkg;

   typedef enum logic [1:0] {
      MODE_TRUNC    = 2'b00,
      MODE_ROUND    = 2'b01,
      MODE_DITHER   = 2'b10,
      MODE_TEMPORAL = 2'b11
   } mode_t;

   // Bayer entry for an N x N matrix, N = 2**log2 (log2 in 1..3).
   // Each bit level contributes a base-4 digit from the 2x2 kernel
   // [[0,2],[3,1]]. The MSB coordinate bits form the least significant digit,
   // which is the recursion B(2n) = 4*B(n) + B(2)-tile.
   function automatic int unsigned bayer_val(input int unsigned x,
                                             input int unsigned y,
                                             input int unsigned log2);
      int unsigned m;
      int unsigned dig;
      m = 0;
      for (int unsigned i = 0; i < 3; i++) begin
         if (i < log2) begin
            dig = ((((x >> i) ^ (y >> i)) & 32'd1) << 1) | ((y >> i) & 32'd1);
            m   = m | (dig << (2 * (log2 - 1 - i)));
         end
      end
      return m;
   endfunction

   // Half an output LSB; zero when no bits are dropped.
   function automatic int unsigned round_offset(input int unsigned d);
      return (d == 0) ? 32'd0 : (32'd1 << (d - 1));
   endfunction

   // Scale a matrix threshold in [0, N^2) onto [0, 2^d).
   function automatic int unsigned dither_offset(input int unsigned mp,
                                                 input int unsigned d,
                                                 input int unsigned log2);
      return (mp << d) >> (2 * log2);
   endfunction

endpackage

// File: rtl/vga_out_stage_if.sv
// Video bus between the framebuffer core and the DAC pins: input pixel and
// syncs, runtime MODE, and the quantised output pixel and syncs.
// Pure wiring; the slave side is the output stage, the master side drives video.
interface vga_out_stage_if #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 4
);
   logic [1:0]          MODE;
   logic                IN_HSYNC;
   logic                IN_VSYNC;
   logic                IN_DE;
   logic [IN_BITS-1:0]  IN_RED;
   logic [IN_BITS-1:0]  IN_GREEN;
   logic [IN_BITS-1:0]  IN_BLUE;
   logic                OUT_HSYNC;
   logic                OUT_VSYNC;
   logic [OUT_BITS-1:0] OUT_RED;
   logic [OUT_BITS-1:0] OUT_GREEN;
   logic [OUT_BITS-1:0] OUT_BLUE;

   modport master (
      output MODE, IN_HSYNC, IN_VSYNC, IN_DE, IN_RED, IN_GREEN, IN_BLUE,
      input  OUT_HSYNC, OUT_VSYNC, OUT_RED, OUT_GREEN, OUT_BLUE
   );

   modport slave (
      input  MODE, IN_HSYNC, IN_VSYNC, IN_DE, IN_RED, IN_GREEN, IN_BLUE,
      output OUT_HSYNC, OUT_VSYNC, OUT_RED, OUT_GREEN, OUT_BLUE
   );
endinterface

// File: rtl/vga_quant_channel.sv
// One colour channel: add offset, shift down by IN_BITS-OUT_BITS, saturate,
// gate with DE; registered output (stage 2, 1 cycle). No backpressure.
// Ports: clk_i, rst_ni, de_i (stage-1 DE), col_i/off_i (stage-1 colour and
// offset), col_o (quantised colour).
module vga_quant_channel #(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                de_i,
   input  logic [IN_BITS-1:0]  col_i,
   input  logic [IN_BITS-1:0]  off_i,
   output logic [OUT_BITS-1:0] col_o
);
   localparam int D = IN_BITS - OUT_BITS;
   localparam logic [IN_BITS:0] MAX_W = (IN_BITS + 1)'((1 << OUT_BITS) - 1);

   logic [IN_BITS:0]    sum;
   logic [IN_BITS:0]    shifted;
   logic [OUT_BITS-1:0] col_d;
   logic [OUT_BITS-1:0] col_q;

   always_comb begin
      // One extra bit of headroom so 0xFF + offset saturates instead of wrapping.
      sum     = {1'b0, col_i} + {1'b0, off_i};
      shifted = sum >> D;
      col_d   = '0;
      if (de_i) begin
         col_d = (shifted > MAX_W) ? MAX_W[OUT_BITS-1:0] : shifted[OUT_BITS-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         col_q <= '0;
      end else begin
         col_q <= col_d;
      end
   end

   assign col_o = col_q;

endmodule

// File: rtl/vga_out_stage.sv
// VGA output stage: quantises 3 colour channels IN_BITS->OUT_BITS using
// truncate/round/Bayer dither/temporal dither; syncs delayed to match.
// Latency 2 cycles for colour and syncs; no backpressure, one pixel per clock.
// Ports: CLK_25MHZ pixel clock, RESET_N async active-low reset, vif (slave
// side of the video bus: MODE, IN_* pixel/syncs in, OUT_* pixel/syncs out).
module vga_out_stage
   import vga_out_pkg::*;
#(
   parameter int IN_BITS         = 8,
   parameter int OUT_BITS        = 4,
   parameter int BAYER_LOG2      = 2,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input logic             CLK_25MHZ,
   input logic             RESET_N,
   vga_out_stage_if.slave  vif
);
   localparam int          D         = IN_BITS - OUT_BITS;
   localparam int unsigned N2        = 32'd1 << (2 * BAYER_LOG2);
   localparam logic        SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

   logic [BAYER_LOG2-1:0] x_q, x_d;
   logic [BAYER_LOG2-1:0] y_q, y_d;
   logic                  parity_q, parity_d;
   mode_t                 mode_q, mode_d;

   // Stage 1 registers
   logic                  s1_hs_q, s1_vs_q, s1_de_q;
   logic [IN_BITS-1:0]    s1_red_q, s1_grn_q, s1_blu_q;
   logic [IN_BITS-1:0]    s1_off_q, off_d;

   // Stage 2 sync registers (colour stage 2 lives in the channels)
   logic                  s2_hs_q, s2_vs_q;

   logic                  vs_edge;
   logic                  de_fall;
   int unsigned           m_val;
   int unsigned           mp_val;

   always_comb begin
      // Stage-1 sync/DE registers double as the previous-cycle samples
      // for edge detection.
      vs_edge  = (vif.IN_VSYNC != SYNC_IDLE) && (s1_vs_q == SYNC_IDLE);
      de_fall  = s1_de_q && !vif.IN_DE;

      x_d      = vif.IN_DE ? x_q + 1'b1 : '0;
      y_d      = y_q;
      if (vs_edge) begin
         y_d = '0;
      end else if (de_fall) begin
         y_d = y_q + 1'b1;
      end
      parity_d = parity_q ^ vs_edge;
      mode_d   = vs_edge ? mode_t'(vif.MODE) : mode_q;

      // Offset for the pixel presented this cycle uses the counters before update.
      m_val    = bayer_val(32'(x_q), 32'(y_q), BAYER_LOG2);
      mp_val   = m_val;
      if ((mode_q == MODE_TEMPORAL) && parity_q) begin
         mp_val = (m_val + N2 / 2) % N2;
      end

      off_d = '0;
      case (mode_q)
         MODE_TRUNC: off_d = '0;
         MODE_ROUND: off_d = IN_BITS'(round_offset(D));
         default:    off_d = IN_BITS'(dither_offset(mp_val, D, BAYER_LOG2));
      endcase
   end

   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         x_q      <= '0;
         y_q      <= '0;
         parity_q <= 1'b0;
         mode_q   <= MODE_TRUNC;
         s1_hs_q  <= SYNC_IDLE;
         s1_vs_q  <= SYNC_IDLE;
         s1_de_q  <= 1'b0;
         s1_red_q <= '0;
         s1_grn_q <= '0;
         s1_blu_q <= '0;
         s1_off_q <= '0;
         s2_hs_q  <= SYNC_IDLE;
         s2_vs_q  <= SYNC_IDLE;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         parity_q <= parity_d;
         mode_q   <= mode_d;
         s1_hs_q  <= vif.IN_HSYNC;
         s1_vs_q  <= vif.IN_VSYNC;
         s1_de_q  <= vif.IN_DE;
         s1_red_q <= vif.IN_RED;
         s1_grn_q <= vif.IN_GREEN;
         s1_blu_q <= vif.IN_BLUE;
         s1_off_q <= off_d;
         s2_hs_q  <= s1_hs_q;
         s2_vs_q  <= s1_vs_q;
      end
   end

   vga_quant_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_red (
      .clk_i (CLK_25MHZ),
      .rst_ni(RESET_N),
      .de_i  (s1_de_q),
      .col_i (s1_red_q),
      .off_i (s1_off_q),
      .col_o (vif.OUT_RED)
   );

   vga_quant_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_green (
      .clk_i (CLK_25MHZ),
      .rst_ni(RESET_N),
      .de_i  (s1_de_q),
      .col_i (s1_grn_q),
      .off_i (s1_off_q),
      .col_o (vif.OUT_GREEN)
   );

   vga_quant_channel #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_blue (
      .clk_i (CLK_25MHZ),
      .rst_ni(RESET_N),
      .de_i  (s1_de_q),
      .col_i (s1_blu_q),
      .off_i (s1_off_q),
      .col_o (vif.OUT_BLUE)
   );

   assign vif.OUT_HSYNC = s2_hs_q;
   assign vif.OUT_VSYNC = s2_vs_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// Testbench for vga_out_stage: randomized video frames with mode changes and
// a mid-line reset, checked against a frame-level reference model.
// Expected pixels are queued at drive time and compared 2 cycles later.
module tb_vga_out_stage;

   localparam int IN_BITS  = 8;
   localparam int OUT_BITS = 4;
   localparam int D        = IN_BITS - OUT_BITS;
   localparam int N        = 4;

   typedef struct {
      int         due;
      logic       hs;
      logic       vs;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t q[$];

   // Reference model state, in frame terms
   int   pix_in_run;    // index of pixel within the current active run
   int   line_in_frame; // active lines completed since the frame began
   int   frame_parity;
   int   frame_mode;
   bit   prev_de;
   bit   prev_vs_active;

   int   bayer4[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
   logic [7:0] corners[5] = '{8'h00, 8'hFF, 8'h17, 8'h18, 8'hF8};

   vga_out_stage_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) vif ();

   vga_out_stage #(
      .IN_BITS        (IN_BITS),
      .OUT_BITS       (OUT_BITS),
      .BAYER_LOG2     (2),
      .SYNC_ACTIVE_LOW(1)
   ) dut (
      .CLK_25MHZ(clk),
      .RESET_N  (rst_n),
      .vif      (vif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] quant(input int c, input int off);
      int v;
      v = (c + off) / (1 << D);
      if (v > (1 << OUT_BITS) - 1) v = (1 << OUT_BITS) - 1;
      return 4'(v);
   endfunction

   function automatic int model_offset();
      int m;
      case (frame_mode)
         0: return 0;
         1: return 1 << (D - 1);
         default: begin
            m = bayer4[(line_in_frame % N) * N + (pix_in_run % N)];
            if (frame_mode == 3 && frame_parity == 1) m = (m + N * N / 2) % (N * N);
            return (m * (1 << D)) / (N * N);
         end
      endcase
   endfunction

   task automatic model_reset();
      pix_in_run     = 0;
      line_in_frame  = 0;
      frame_parity   = 0;
      frame_mode     = 0;
      prev_de        = 1'b0;
      prev_vs_active = 1'b0;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Drive one pixel clock of video; queue what must appear 2 cycles later.
   task automatic step(input logic hs, input logic vs, input logic de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      exp_t e;
      int   off;
      bit   vs_active;
      @(negedge clk);
      vif.IN_HSYNC = hs;
      vif.IN_VSYNC = vs;
      vif.IN_DE    = de;
      vif.IN_RED   = r;
      vif.IN_GREEN = g;
      vif.IN_BLUE  = b;

      e.due = cyc + 2;
      e.hs  = hs;
      e.vs  = vs;
      e.r   = 4'h0;
      e.g   = 4'h0;
      e.b   = 4'h0;
      if (de) begin
         off = model_offset();
         e.r = quant(int'(r), off);
         e.g = quant(int'(g), off);
         e.b = quant(int'(b), off);
      end
      q.push_back(e);

      vs_active = (vs == 1'b0);
      if (de) pix_in_run++;
      else    pix_in_run = 0;
      if (vs_active && !prev_vs_active) begin
         line_in_frame = 0;
         frame_parity  = 1 - frame_parity;
         frame_mode    = int'(vif.MODE);
      end else if (prev_de && !de) begin
         line_in_frame++;
      end
      prev_de        = de;
      prev_vs_active = vs_active;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      model_reset();
      #1;
      check("rst_red",   int'(vif.OUT_RED),   0);
      check("rst_green", int'(vif.OUT_GREEN), 0);
      check("rst_blue",  int'(vif.OUT_BLUE),  0);
      check("rst_hsync", int'(vif.OUT_HSYNC), 1);
      check("rst_vsync", int'(vif.OUT_VSYNC), 1);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   function automatic logic [7:0] pick(input int fixed);
      if (fixed >= 0) return 8'(fixed);
      if ($urandom_range(0, 2) == 0) return corners[$urandom_range(0, 4)];
      return 8'($urandom);
   endfunction

   task automatic frame(input int fixed, input logic [1:0] next_mode, input int reset_line);
      int w;
      repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int ln = 0; ln < 6; ln++) begin
         repeat (2) step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
         repeat (2) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
         w = $urandom_range(4, 9);
         for (int px = 0; px < w; px++) begin
            if (ln == 2 && px == 2) vif.MODE = next_mode;
            if (ln == reset_line && px == 3) do_reset();
            step(1'b1, 1'b1, 1'b1, pick(fixed), pick(fixed), pick(fixed));
         end
         step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      end
   endtask

   // Monitor: after each rising edge, compare whatever expectation is due now.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.due < cyc) begin
               n_fail++;
               $display("FAIL pixel_late: due cycle %0d not seen, now cycle %0d", e.due, cyc);
            end else if ({vif.OUT_HSYNC, vif.OUT_VSYNC, vif.OUT_RED, vif.OUT_GREEN, vif.OUT_BLUE}
                         !== {e.hs, e.vs, e.r, e.g, e.b}) begin
               n_fail++;
               $display("FAIL pixel cyc=%0d: got hs=%b vs=%b rgb=%h%h%h expected hs=%b vs=%b rgb=%h%h%h",
                        cyc, vif.OUT_HSYNC, vif.OUT_VSYNC, vif.OUT_RED, vif.OUT_GREEN, vif.OUT_BLUE,
                        e.hs, e.vs, e.r, e.g, e.b);
            end
         end
      end
   end

   initial begin
      cyc          = 0;
      n_checks     = 0;
      n_fail       = 0;
      rst_n        = 1'b0;
      vif.MODE     = 2'b10;
      vif.IN_HSYNC = 1'b1;
      vif.IN_VSYNC = 1'b1;
      vif.IN_DE    = 1'b0;
      vif.IN_RED   = 8'h00;
      vif.IN_GREEN = 8'h00;
      vif.IN_BLUE  = 8'h00;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("init_red",   int'(vif.OUT_RED),   0);
      check("init_green", int'(vif.OUT_GREEN), 0);
      check("init_blue",  int'(vif.OUT_BLUE),  0);
      check("init_hsync", int'(vif.OUT_HSYNC), 1);
      check("init_vsync", int'(vif.OUT_VSYNC), 1);
      #2 rst_n = 1'b1;

      // Before any VSYNC edge the stage truncates even though MODE says dither.
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (6) step(1'b1, 1'b1, 1'b1, 8'hAB, 8'hAB, 8'hAB);
      step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

      for (int pass = 0; pass < 2; pass++) begin
         frame(8'h18, 2'b11, -1);  // dither, parity 1
         frame(8'h18, 2'b11, -1);  // temporal, parity 0
         frame(8'h18, 2'b01, -1);  // temporal, parity 1
         frame(-1,    2'b00, -1);  // round with corner values
         frame(-1,    2'b10, -1);  // truncate
         frame(-1,    2'b11,  3);  // dither, reset mid-line
         frame(-1,    2'b01, -1);  // temporal after reset
         frame(-1,    2'b10, -1);  // round
      end

      repeat (4) step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (4) @(negedge clk);
      check("queue_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
